// File: rtl/multichannel_delay_line.sv
// multichannel_delay_line
//   Runtime-programmable sample delay for CHANNELS interleaved channels on one
//   shared circular RAM of DEPTH frames. One beat per cycle, no backpressure.
//   Output is forced to zero until enough frames have been written, so stale
//   RAM contents never reach the output.
//
// Ports
//   clk          clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   in_valid     input beat strobe (channel order 0..CHANNELS-1 implied)
//   in_data      input sample
//   delay_cfg    requested delay in samples
//   delay_load   pulse: latch clamp(delay_cfg) as pending delay
//   out_valid    output beat strobe, two edges after the input beat
//   out_channel  channel index of out_data
//   out_data     delayed sample (zero while history is insufficient)
//   primed       registered: completed frames >= delay of the current frame
//   cfg_err      sticky: a clamped delay_cfg was loaded
module multichannel_delay_line #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4096,
  parameter int CHANNELS      = 2,
  parameter int DELAY_WIDTH   = $clog2(DEPTH),
  parameter int DEFAULT_DELAY = 1
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             in_valid,
  input  logic [DATA_WIDTH-1:0]                            in_data,
  input  logic [DELAY_WIDTH-1:0]                           delay_cfg,
  input  logic                                             delay_load,
  output logic                                             out_valid,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_channel,
  output logic [DATA_WIDTH-1:0]                            out_data,
  output logic                                             primed,
  output logic                                             cfg_err
);

  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int WORDS  = DEPTH * CHANNELS;
  localparam int ADDR_W = $clog2(WORDS);

  localparam logic [DELAY_WIDTH-1:0] MAX_DELAY  = DELAY_WIDTH'(DEPTH - 1);
  localparam logic [DELAY_WIDTH-1:0] INIT_DELAY = DELAY_WIDTH'(DEFAULT_DELAY);
  localparam logic [PTR_W-1:0]       LAST_PTR   = PTR_W'(DEPTH - 1);
  localparam logic [CH_W-1:0]        LAST_CH    = CH_W'(CHANNELS - 1);

  // Frame / pointer state
  logic [PTR_W-1:0]       wr_ptr;
  logic [CH_W-1:0]        ch_cnt;
  logic [PTR_W-1:0]       fill_count;
  logic [DELAY_WIDTH-1:0] active_delay;
  logic [DELAY_WIDTH-1:0] pending_delay;

  // Combinational helpers
  logic [DELAY_WIDTH-1:0] cfg_clamped;
  logic                   cfg_bad;
  logic [DELAY_WIDTH-1:0] eff_delay;
  logic [PTR_W-1:0]       eff_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [ADDR_W-1:0]      wr_addr;
  logic [ADDR_W-1:0]      rd_addr;
  logic                   frame_start;

  // Pipeline
  logic [DATA_WIDTH-1:0]  mem [WORDS];
  logic [DATA_WIDTH-1:0]  rd_q;
  logic                   s1_valid;
  logic [CH_W-1:0]        s1_ch;
  logic                   s1_zero;
  logic                   s2_valid;
  logic [CH_W-1:0]        s2_ch;
  logic [DATA_WIDTH-1:0]  s2_data;

  always_comb begin
    cfg_clamped = delay_cfg;
    cfg_bad     = 1'b0;
    if (delay_cfg == '0) begin
      cfg_clamped = DELAY_WIDTH'(1);
      cfg_bad     = 1'b1;
    end else if (delay_cfg > MAX_DELAY) begin
      cfg_clamped = MAX_DELAY;
      cfg_bad     = 1'b1;
    end
  end

  // At a frame boundary the pending delay is the one in force, so a ch0 beat
  // already uses it even though active_delay only catches up on this edge.
  assign frame_start = (ch_cnt == '0);
  assign eff_delay   = frame_start ? pending_delay : active_delay;
  assign eff_ptr     = PTR_W'(eff_delay);

  // Ring subtraction: PTR_W'(DEPTH) - eff wraps to DEPTH - eff for both
  // power-of-two and non-power-of-two depths.
  always_comb begin
    if (wr_ptr >= eff_ptr) rd_ptr = wr_ptr - eff_ptr;
    else                   rd_ptr = wr_ptr + (PTR_W'(DEPTH) - eff_ptr);
  end

  assign wr_addr = ADDR_W'(wr_ptr) * ADDR_W'(CHANNELS) + ADDR_W'(ch_cnt);
  assign rd_addr = ADDR_W'(rd_ptr) * ADDR_W'(CHANNELS) + ADDR_W'(ch_cnt);

  // Storage: not reset. Read and write never share an address (delay >= 1).
  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem[wr_addr] <= in_data;
      rd_q         <= mem[rd_addr];
    end
  end

  // Counters and delay registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      ch_cnt        <= '0;
      fill_count    <= '0;
      active_delay  <= INIT_DELAY;
      pending_delay <= INIT_DELAY;
      primed        <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      if (frame_start) active_delay <= pending_delay;
      if (delay_load) begin
        pending_delay <= cfg_clamped;
        if (cfg_bad) cfg_err <= 1'b1;
      end
      if (in_valid) begin
        if (frame_start) primed <= (fill_count >= eff_ptr);
        if (ch_cnt == LAST_CH) begin
          ch_cnt <= '0;
          wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
          if (fill_count != LAST_PTR) fill_count <= fill_count + 1'b1;
        end else begin
          ch_cnt <= ch_cnt + 1'b1;
        end
      end
    end
  end

  // Three-register output path: read capture, gating, output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_ch       <= '0;
      s1_zero     <= 1'b1;
      s2_valid    <= 1'b0;
      s2_ch       <= '0;
      s2_data     <= '0;
      out_valid   <= 1'b0;
      out_channel <= '0;
      out_data    <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_ch   <= ch_cnt;
        s1_zero <= (fill_count < eff_ptr);
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ch   <= s1_ch;
        s2_data <= s1_zero ? '0 : rd_q;
      end
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_channel <= s2_ch;
        out_data    <= s2_data;
      end
    end
  end

endmodule

// File: tb/tb_multichannel_delay_line.sv
module tb_multichannel_delay_line;

  localparam int DW  = 16;
  localparam int DEP = 12;
  localparam int CH  = 3;
  localparam int LW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [LW-1:0] delay_cfg;
  logic          delay_load;
  logic          out_valid;
  logic [1:0]    out_channel;
  logic [DW-1:0] out_data;
  logic          primed;
  logic          cfg_err;

  multichannel_delay_line #(
    .DATA_WIDTH(DW), .DEPTH(DEP), .CHANNELS(CH), .DELAY_WIDTH(LW), .DEFAULT_DELAY(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .delay_cfg(delay_cfg), .delay_load(delay_load), .out_valid(out_valid),
    .out_channel(out_channel), .out_data(out_data), .primed(primed), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit      v;
    int      ch;
    logic [DW-1:0] d;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-channel sample history indexed by frame number.
  logic [DW-1:0] hist [CH][4096];
  int   frames, m_ch, pending, frame_delay;
  bit   m_primed, m_cfg_err;
  exp_t e1, e2, en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    frames = 0; m_ch = 0; pending = 1; frame_delay = 1;
    m_primed = 0; m_cfg_err = 0;
    e1.v = 0; e2.v = 0;
  endtask

  task automatic step(input bit v, input logic [DW-1:0] d, input bit ld, input logic [LW-1:0] cfg);
    int c;
    int fill;
    in_valid = v; in_data = d; delay_load = ld; delay_cfg = cfg;
    @(posedge clk); #1;
    en.v = v; en.ch = 0; en.d = '0;
    if (v) begin
      if (m_ch == 0) begin
        frame_delay = pending;
        fill = (frames > DEP - 1) ? DEP - 1 : frames;
        m_primed = (fill >= frame_delay);
      end
      en.ch = m_ch;
      en.d  = (frames < frame_delay) ? '0 : hist[m_ch][frames - frame_delay];
      hist[m_ch][frames] = d;
      m_ch++;
      if (m_ch == CH) begin m_ch = 0; frames++; end
    end
    if (ld) begin
      c = int'(cfg);
      if (c == 0)            begin c = 1;       m_cfg_err = 1; end
      else if (c > DEP - 1)  begin c = DEP - 1; m_cfg_err = 1; end
      pending = c;
    end
    check("out_valid", 32'(out_valid), 32'(e2.v));
    if (e2.v) begin
      check("out_channel", 32'(out_channel), 32'(e2.ch));
      check("out_data", 32'(out_data), 32'(e2.d));
    end
    check("primed", 32'(primed), 32'(m_primed));
    check("cfg_err", 32'(cfg_err), 32'(m_cfg_err));
    e2 = e1; e1 = en;
  endtask

  task automatic do_reset();
    in_valid = 0; delay_load = 0;
    rst_n = 0;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'd0);
    check("rst_async_data", 32'(out_data), 32'd0);
    check("rst_async_primed", 32'(primed), 32'd0);
    check("rst_async_cfg_err", 32'(cfg_err), 32'd0);
    @(posedge clk); #1;
    check("rst_hold_valid", 32'(out_valid), 32'd0);
    rst_n = 1;
    model_reset();
  endtask

  task automatic frame(input int k);
    for (int c = 0; c < CH; c++) step(1'b1, DW'(100 * c + k), 1'b0, '0);
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_data = '0; delay_cfg = '0; delay_load = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_channel", 32'(out_channel), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_primed", 32'(primed), 32'd0);
    check("reset_cfg_err", 32'(cfg_err), 32'd0);
    rst_n = 1;
    model_reset();

    // Back-to-back frames at the default delay of 1
    for (int k = 1; k <= 5; k++) frame(k);
    step(0, '0, 0, '0);
    step(0, '0, 0, '0);

    // Load mid-frame: current frame keeps the old delay
    step(1, DW'(6), 0, '0);
    step(0, '0, 1, 4'd3);
    step(1, DW'(106), 0, '0);
    step(1, DW'(206), 0, '0);
    for (int k = 7; k <= 9; k++) frame(k);

    // Longer delay across several ring wraps
    step(0, '0, 1, 4'd5);
    for (int k = 10; k <= 35; k++) frame(k);
    repeat (3) step(0, '0, 0, '0);

    // Clamping and sticky error
    step(0, '0, 1, 4'd0);
    step(1, DW'(1), 0, '0);
    step(1, DW'(2), 1, 4'd12);
    step(1, DW'(3), 0, '0);
    step(0, '0, 1, 4'd15);
    for (int k = 40; k <= 53; k++) frame(k);
    step(0, '0, 1, 4'd4);
    for (int k = 54; k <= 58; k++) frame(k);
    repeat (3) step(0, '0, 0, '0);
    do_reset();

    // Reset with beats in flight
    frame(1);
    frame(2);
    step(1, DW'(3), 0, '0);
    do_reset();
    step(1, DW'(77), 0, '0);
    step(1, DW'(78), 0, '0);
    for (int k = 4; k <= 6; k++) frame(k);
    repeat (3) step(0, '0, 0, '0);

    // Random gaps, delay 2, then random reloads including clamped values
    step(0, '0, 1, 4'd2);
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 9) < 6), DW'($urandom), 1'b0, '0);
    for (int i = 0; i < 500; i++) begin
      if (i == 250) do_reset();
      step(($urandom_range(0, 9) < 7), DW'($urandom),
           ($urandom_range(0, 19) == 0), LW'($urandom_range(0, 15)));
    end
    repeat (3) step(0, '0, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
